// File: rtl/sequenciador_jogo_pkg.sv
// Shared definitions for the Sudoku game-flow controller.
//  - estado_t    : game state encoding, also driven out as estado_jogo
//  - enables_t   : one-hot unit enables that accompany each state
//  - DIGITO_MIN/DIGITO_MAX and digito_legal(): legal user digit range
//  - enables_de(): maps a state to its unit enable vector
package sequenciador_jogo_pkg;

  typedef enum logic [2:0] {
    RECEBE_LINHA  = 3'b000,
    RECEBE_COLUNA = 3'b001,
    VERIFICA_POS  = 3'b010,
    RECEBE_VALOR  = 3'b011,
    VERIFICA_JOGO = 3'b100,
    FIM_JOGO      = 3'b101
  } estado_t;

  localparam logic [3:0] DIGITO_MIN = 4'd1;
  localparam logic [3:0] DIGITO_MAX = 4'd9;

  typedef struct packed {
    logic recebe_entrada;
    logic verifica_pos;
    logic verifica_jogo;
    logic fim_jogo;
  } enables_t;

  function automatic logic digito_legal(input logic [3:0] digito);
    return (digito >= DIGITO_MIN) && (digito <= DIGITO_MAX);
  endfunction

  // Every state maps to exactly one enable; unknown encodings fall back to
  // the entry unit so the outputs stay one-hot.
  function automatic enables_t enables_de(input estado_t estado);
    enables_t en;
    en = '0;
    case (estado)
      VERIFICA_POS:  en.verifica_pos   = 1'b1;
      VERIFICA_JOGO: en.verifica_jogo  = 1'b1;
      FIM_JOGO:      en.fim_jogo       = 1'b1;
      default:       en.recebe_entrada = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/sequenciador_jogo_contador_timeout.sv
// Checker watchdog counter.
//  clk, reset : clock and asynchronous active-high reset
//  clear      : forces the count to zero (priority over enable)
//  enable     : count one cycle spent waiting for a checker
//  expira     : high while enabled on the last allowed cycle (count == TIMEOUT_CICLOS-1)
module sequenciador_jogo_contador_timeout #(
  parameter int TIMEOUT_CICLOS = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expira
);

  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      // Wrap rather than overflow; the controller leaves the state on expiry anyway.
      cnt_d = (cnt_q == LIMITE) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expira = enable && (cnt_q == LIMITE);

endmodule

// File: rtl/sequenciador_jogo.sv
// Game-flow controller for the Sudoku core.
// Captures row/column/value digits, hands off to the position and board
// checkers and waits for their done pulses (with a watchdog), counts moves and
// errors, and ends the game on win or error limit. reiniciar restarts from any
// state.
//  Inputs : clk, reset (async, active-high), reiniciar, entrada_valida, entrada[3:0],
//           pos_done/pos_livre, jogo_done/jogo_valido/jogo_completo
//  Outputs: estado_jogo[2:0], one-hot registered unit enables, latched linha/coluna/valor,
//           erros, jogadas (saturating), sticky vitoria/derrota, timeout_evt pulse
module sequenciador_jogo
  import sequenciador_jogo_pkg::*;
#(
  parameter int MAX_ERROS      = 3,
  parameter int TIMEOUT_CICLOS = 50_000_000,
  parameter int CNT_W          = 26,
  parameter int ERR_W          = 2,
  parameter int JOG_W          = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reiniciar,
  input  logic             entrada_valida,
  input  logic [3:0]       entrada,
  input  logic             pos_done,
  input  logic             pos_livre,
  input  logic             jogo_done,
  input  logic             jogo_valido,
  input  logic             jogo_completo,
  output logic [2:0]       estado_jogo,
  output logic             enable_recebe_entrada,
  output logic             enable_verifica_pos,
  output logic             enable_verifica_jogo,
  output logic             enable_fim_jogo,
  output logic [3:0]       linha,
  output logic [3:0]       coluna,
  output logic [3:0]       valor,
  output logic [ERR_W-1:0] erros,
  output logic [JOG_W-1:0] jogadas,
  output logic             vitoria,
  output logic             derrota,
  output logic             timeout_evt
);

  estado_t          estado_q, estado_d;
  enables_t         enables_q;
  logic [3:0]       linha_q, linha_d;
  logic [3:0]       coluna_q, coluna_d;
  logic [3:0]       valor_q, valor_d;
  logic [ERR_W-1:0] erros_q, erros_d;
  logic [JOG_W-1:0] jogadas_q, jogadas_d;
  logic             vitoria_q, vitoria_d;
  logic             derrota_q, derrota_d;
  logic             timeout_evt_q, timeout_evt_d;

  logic em_verifica;
  logic expira;
  logic digito_ok;

  assign em_verifica = (estado_q == VERIFICA_POS) || (estado_q == VERIFICA_JOGO);
  assign digito_ok   = entrada_valida && digito_legal(entrada);

  // Held at zero outside the verify states, so each entry starts from zero.
  sequenciador_jogo_contador_timeout #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .CNT_W          (CNT_W)
  ) u_contador_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (reiniciar || !em_verifica),
    .enable (em_verifica),
    .expira (expira)
  );

  always_comb begin
    estado_d      = estado_q;
    linha_d       = linha_q;
    coluna_d      = coluna_q;
    valor_d       = valor_q;
    erros_d       = erros_q;
    jogadas_d     = jogadas_q;
    vitoria_d     = vitoria_q;
    derrota_d     = derrota_q;
    timeout_evt_d = 1'b0;

    if (reiniciar) begin
      estado_d  = RECEBE_LINHA;
      linha_d   = '0;
      coluna_d  = '0;
      valor_d   = '0;
      erros_d   = '0;
      jogadas_d = '0;
      vitoria_d = 1'b0;
      derrota_d = 1'b0;
    end else begin
      case (estado_q)
        RECEBE_LINHA: begin
          if (digito_ok) begin
            linha_d  = entrada;
            estado_d = RECEBE_COLUNA;
          end
        end
        RECEBE_COLUNA: begin
          if (digito_ok) begin
            coluna_d = entrada;
            estado_d = VERIFICA_POS;
          end
        end
        VERIFICA_POS: begin
          // A done arriving on the expiry cycle beats the watchdog.
          if (pos_done) begin
            estado_d = pos_livre ? RECEBE_VALOR : RECEBE_LINHA;
          end else if (expira) begin
            timeout_evt_d = 1'b1;
            estado_d      = RECEBE_LINHA;
          end
        end
        RECEBE_VALOR: begin
          if (digito_ok) begin
            valor_d  = entrada;
            estado_d = VERIFICA_JOGO;
            if (jogadas_q != '1) jogadas_d = jogadas_q + JOG_W'(1);
          end
        end
        VERIFICA_JOGO: begin
          if (jogo_done) begin
            if (jogo_completo) begin
              vitoria_d = 1'b1;
              estado_d  = FIM_JOGO;
            end else if (!jogo_valido) begin
              erros_d = erros_q + ERR_W'(1);
              if (erros_d == ERR_W'(MAX_ERROS)) begin
                derrota_d = 1'b1;
                estado_d  = FIM_JOGO;
              end else begin
                estado_d = RECEBE_LINHA;
              end
            end else begin
              estado_d = RECEBE_LINHA;
            end
          end else if (expira) begin
            timeout_evt_d = 1'b1;
            estado_d      = RECEBE_LINHA;
          end
        end
        FIM_JOGO: ;
        default: estado_d = RECEBE_LINHA;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q      <= RECEBE_LINHA;
      enables_q     <= enables_de(RECEBE_LINHA);
      linha_q       <= '0;
      coluna_q      <= '0;
      valor_q       <= '0;
      erros_q       <= '0;
      jogadas_q     <= '0;
      vitoria_q     <= 1'b0;
      derrota_q     <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      // Decoded from the next state so enables move on the same edge as estado_jogo.
      enables_q     <= enables_de(estado_d);
      linha_q       <= linha_d;
      coluna_q      <= coluna_d;
      valor_q       <= valor_d;
      erros_q       <= erros_d;
      jogadas_q     <= jogadas_d;
      vitoria_q     <= vitoria_d;
      derrota_q     <= derrota_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign estado_jogo           = estado_q;
  assign enable_recebe_entrada = enables_q.recebe_entrada;
  assign enable_verifica_pos   = enables_q.verifica_pos;
  assign enable_verifica_jogo  = enables_q.verifica_jogo;
  assign enable_fim_jogo       = enables_q.fim_jogo;
  assign linha                 = linha_q;
  assign coluna                = coluna_q;
  assign valor                 = valor_q;
  assign erros                 = erros_q;
  assign jogadas               = jogadas_q;
  assign vitoria               = vitoria_q;
  assign derrota               = derrota_q;
  assign timeout_evt           = timeout_evt_q;

endmodule

// File: tb/tb_sequenciador_jogo.sv
// Directed self-checking bench for sequenciador_jogo (MAX_ERROS=3, TIMEOUT_CICLOS=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sequenciador_jogo;

  localparam int MAX_ERROS      = 3;
  localparam int TIMEOUT_CICLOS = 8;
  localparam int CNT_W          = 4;
  localparam int ERR_W          = 2;
  localparam int JOG_W          = 7;

  logic             clk;
  logic             reset;
  logic             reiniciar;
  logic             entrada_valida;
  logic [3:0]       entrada;
  logic             pos_done;
  logic             pos_livre;
  logic             jogo_done;
  logic             jogo_valido;
  logic             jogo_completo;
  logic [2:0]       estado_jogo;
  logic             enable_recebe_entrada;
  logic             enable_verifica_pos;
  logic             enable_verifica_jogo;
  logic             enable_fim_jogo;
  logic [3:0]       linha;
  logic [3:0]       coluna;
  logic [3:0]       valor;
  logic [ERR_W-1:0] erros;
  logic [JOG_W-1:0] jogadas;
  logic             vitoria;
  logic             derrota;
  logic             timeout_evt;

  logic [3:0] en;
  assign en = {enable_recebe_entrada, enable_verifica_pos, enable_verifica_jogo, enable_fim_jogo};

  int n_checks = 0;
  int n_pass   = 0;

  sequenciador_jogo #(
    .MAX_ERROS      (MAX_ERROS),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .CNT_W          (CNT_W),
    .ERR_W          (ERR_W),
    .JOG_W          (JOG_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .reiniciar             (reiniciar),
    .entrada_valida        (entrada_valida),
    .entrada               (entrada),
    .pos_done              (pos_done),
    .pos_livre             (pos_livre),
    .jogo_done             (jogo_done),
    .jogo_valido           (jogo_valido),
    .jogo_completo         (jogo_completo),
    .estado_jogo           (estado_jogo),
    .enable_recebe_entrada (enable_recebe_entrada),
    .enable_verifica_pos   (enable_verifica_pos),
    .enable_verifica_jogo  (enable_verifica_jogo),
    .enable_fim_jogo       (enable_fim_jogo),
    .linha                 (linha),
    .coluna                (coluna),
    .valor                 (valor),
    .erros                 (erros),
    .jogadas               (jogadas),
    .vitoria               (vitoria),
    .derrota               (derrota),
    .timeout_evt           (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_entrada(input logic [3:0] d);
    entrada = d; entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
  endtask

  task automatic pulse_pos(input logic livre);
    pos_done = 1'b1; pos_livre = livre;
    tick();
    pos_done = 1'b0; pos_livre = 1'b0;
  endtask

  task automatic pulse_jogo(input logic valido, input logic completo);
    jogo_done = 1'b1; jogo_valido = valido; jogo_completo = completo;
    tick();
    jogo_done = 1'b0; jogo_valido = 1'b0; jogo_completo = 1'b0;
  endtask

  task automatic pulse_reiniciar();
    reiniciar = 1'b1;
    tick();
    reiniciar = 1'b0;
  endtask

  task automatic jogada(input logic [3:0] l, input logic [3:0] c, input logic [3:0] v,
                        input logic valido, input logic completo);
    pulse_entrada(l);
    pulse_entrada(c);
    pulse_pos(1'b1);
    pulse_entrada(v);
    pulse_jogo(valido, completo);
  endtask

  initial begin
    int first_evt;
    int n_evt;

    reset = 1'b1; reiniciar = 1'b0; entrada_valida = 1'b0; entrada = '0;
    pos_done = 1'b0; pos_livre = 1'b0; jogo_done = 1'b0; jogo_valido = 1'b0; jogo_completo = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state after idling
    repeat (20) tick();
    check("reset_estado", estado_jogo, 3'b000);
    check("reset_en", en, 4'b1000);
    check("reset_contadores", {erros, jogadas}, '0);
    check("reset_campos", {linha, coluna, valor}, '0);
    check("reset_flags", {vitoria, derrota, timeout_evt}, 3'b000);

    // One full valid move, step by step
    pulse_entrada(4'd3);
    check("linha_estado", estado_jogo, 3'b001);
    check("linha_3", linha, 4'd3);
    pulse_entrada(4'd7);
    check("coluna_estado", estado_jogo, 3'b010);
    check("coluna_7", coluna, 4'd7);
    check("en_verifica_pos", en, 4'b0100);
    pulse_entrada(4'd2);  // ignored while verifying
    check("verifica_ignora_entrada", {estado_jogo, coluna}, {3'b010, 4'd7});
    pulse_pos(1'b1);
    check("pos_livre_estado", estado_jogo, 3'b011);
    check("en_recebe_valor", en, 4'b1000);
    pulse_entrada(4'd5);
    check("valor_estado", estado_jogo, 3'b100);
    check("valor_5", valor, 4'd5);
    check("jogadas_1", jogadas, 7'd1);
    check("en_verifica_jogo", en, 4'b0010);
    pulse_jogo(1'b1, 1'b0);
    check("jogo_valido_estado", estado_jogo, 3'b000);
    check("jogo_valido_erros", erros, 2'd0);

    // Illegal digits and stray done pulses in RECEBE_LINHA
    pulse_entrada(4'd0);
    check("digito_0_ignorado", {estado_jogo, linha}, {3'b000, 4'd3});
    pulse_entrada(4'd12);
    check("digito_12_ignorado", {estado_jogo, linha}, {3'b000, 4'd3});
    pulse_pos(1'b1);
    check("pos_done_fora_ignorado", estado_jogo, 3'b000);
    pulse_entrada(4'd9);
    check("digito_9", {estado_jogo, linha}, {3'b001, 4'd9});

    // Occupied cell returns to RECEBE_LINHA without an error
    pulse_entrada(4'd1);
    pulse_pos(1'b0);
    check("pos_ocupada", {estado_jogo, 2'(erros)}, {3'b000, 2'd0});

    // Three rule violations end the game in defeat
    jogada(4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    check("erro_1", {estado_jogo, 2'(erros)}, {3'b000, 2'd1});
    jogada(4'd4, 4'd5, 4'd6, 1'b0, 1'b0);
    check("erro_2", {estado_jogo, 2'(erros)}, {3'b000, 2'd2});
    jogada(4'd7, 4'd8, 4'd9, 1'b0, 1'b0);
    check("erro_3_estado", estado_jogo, 3'b101);
    check("erro_3_erros", erros, 2'd3);
    check("derrota", {vitoria, derrota}, 2'b01);
    check("en_fim", en, 4'b0001);
    check("jogadas_4", jogadas, 7'd4);
    pulse_entrada(4'd4);
    pulse_jogo(1'b1, 1'b1);
    check("fim_segura", {estado_jogo, valor, 2'(erros)}, {3'b101, 4'd9, 2'd3});

    // Restart from FIM_JOGO
    pulse_reiniciar();
    check("reinicia_estado", estado_jogo, 3'b000);
    check("reinicia_limpa", {2'(erros), 7'(jogadas), vitoria, derrota, linha}, '0);
    check("reinicia_en", en, 4'b1000);

    // Watchdog expiry: single pulse 8 cycles after entering VERIFICA_POS
    pulse_entrada(4'd2);
    pulse_entrada(4'd2);
    first_evt = -1;
    n_evt = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (timeout_evt) begin
        n_evt++;
        if (first_evt < 0) first_evt = i;
      end
      if (i == 8) check("timeout_estado", {estado_jogo, 2'(erros)}, {3'b000, 2'd0});
    end
    check("timeout_ciclo", first_evt, 8);
    check("timeout_uma_vez", n_evt, 1);

    // Done on the expiry cycle wins over the watchdog
    pulse_entrada(4'd2);
    pulse_entrada(4'd3);
    repeat (7) tick();
    check("antes_expirar", {estado_jogo, timeout_evt}, {3'b010, 1'b0});
    pulse_pos(1'b1);
    check("done_vence_timeout", {estado_jogo, timeout_evt}, {3'b011, 1'b0});

    // Complete board: victory
    pulse_entrada(4'd4);
    pulse_jogo(1'b1, 1'b1);
    check("vitoria_estado", estado_jogo, 3'b101);
    check("vitoria_flags", {vitoria, derrota}, 2'b10);
    check("vitoria_jogadas", jogadas, 7'd1);

    // Restart wins over a simultaneous jogo_done in VERIFICA_JOGO
    pulse_reiniciar();
    pulse_entrada(4'd1);
    pulse_entrada(4'd1);
    pulse_pos(1'b1);
    pulse_entrada(4'd2);
    check("pre_reinicia_verifica", estado_jogo, 3'b100);
    reiniciar = 1'b1; jogo_done = 1'b1; jogo_valido = 1'b0; jogo_completo = 1'b1;
    tick();
    reiniciar = 1'b0; jogo_done = 1'b0; jogo_completo = 1'b0;
    check("reinicia_verifica_estado", estado_jogo, 3'b000);
    check("reinicia_verifica_limpa", {2'(erros), 7'(jogadas), vitoria, derrota}, '0);

    // Move counter saturates at all-ones
    for (int m = 0; m < 130; m++) jogada(4'd5, 4'd5, 4'd5, 1'b1, 1'b0);
    check("jogadas_satura", jogadas, 7'd127);
    check("satura_estado", {estado_jogo, 2'(erros)}, {3'b000, 2'd0});

    // Asynchronous reset mid-verify
    pulse_entrada(4'd6);
    pulse_entrada(4'd6);
    #3 reset = 1'b1;
    #1;
    check("reset_async_estado", estado_jogo, 3'b000);
    check("reset_async_limpa", {7'(jogadas), linha, coluna, valor}, '0);
    check("reset_async_en", en, 4'b1000);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) tick();
    check("reset_async_sem_pulso", {estado_jogo, timeout_evt}, {3'b000, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
